// File: rtl/testpattern_pkg.sv
// testpattern_pkg: shared types and constants for the HDMI test-pattern controller.
//   preset_t    - one video timing preset (8 x 12-bit timing fields + sync polarities)
//   PRESET      - the four selectable timing presets, indexed 0..3
//   MODE_*      - generator pattern-select codes
//   state_t     - controller FSM states
//   next_mode() - pattern sequencing order 0->1->2->3->4->0
package testpattern_pkg;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        hs_pol;  // 1 = positive sync
    logic        vs_pol;  // 1 = positive sync
  } preset_t;

  localparam preset_t PRESET [0:3] = '{
    '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525,  12'd2, 12'd33, 12'd480,  1'b0, 1'b0},
    '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750,  12'd5, 12'd20, 12'd720,  1'b1, 1'b1},
    '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628,  12'd4, 12'd23, 12'd600,  1'b1, 1'b1},
    '{12'd2200, 12'd44,  12'd148, 12'd1920, 12'd1125, 12'd5, 12'd36, 12'd1080, 1'b1, 1'b1}
  };

  localparam logic [2:0] MODE_BAR    = 3'd0;
  localparam logic [2:0] MODE_GRID   = 3'd1;
  localparam logic [2:0] MODE_GRAY   = 3'd2;
  localparam logic [2:0] MODE_SINGLE = 3'd3;
  localparam logic [2:0] MODE_BLUE   = 3'd4;

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Pattern order; any out-of-range code recovers to the colour bars.
  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      MODE_BAR:    next_mode = MODE_GRID;
      MODE_GRID:   next_mode = MODE_GRAY;
      MODE_GRAY:   next_mode = MODE_SINGLE;
      MODE_SINGLE: next_mode = MODE_BLUE;
      default:     next_mode = MODE_BAR;
    endcase
  endfunction

endpackage

// File: rtl/testpattern_if.sv
// testpattern_if: bundle between the controller and the test-pattern generator.
//   I_vs                 - raw generator VS (polarity encoded), generator -> controller
//   O_mode               - pattern select
//   O_single_r/g/b       - single-colour level
//   O_h_*/O_v_*          - timing preset fields
//   O_hs_pol/O_vs_pol    - sync polarities (1 = positive)
//   O_gen_rst_n          - generator reset, active-low
// master = controller side, slave = generator side.
interface testpattern_if;
  logic        I_vs;
  logic [2:0]  O_mode;
  logic [7:0]  O_single_r;
  logic [7:0]  O_single_g;
  logic [7:0]  O_single_b;
  logic [11:0] O_h_total;
  logic [11:0] O_h_sync;
  logic [11:0] O_h_bporch;
  logic [11:0] O_h_res;
  logic [11:0] O_v_total;
  logic [11:0] O_v_sync;
  logic [11:0] O_v_bporch;
  logic [11:0] O_v_res;
  logic        O_hs_pol;
  logic        O_vs_pol;
  logic        O_gen_rst_n;

  modport master (
    input  I_vs,
    output O_mode, O_single_r, O_single_g, O_single_b,
    output O_h_total, O_h_sync, O_h_bporch, O_h_res,
    output O_v_total, O_v_sync, O_v_bporch, O_v_res,
    output O_hs_pol, O_vs_pol, O_gen_rst_n
  );

  modport slave (
    output I_vs,
    input  O_mode, O_single_r, O_single_g, O_single_b,
    input  O_h_total, O_h_sync, O_h_bporch, O_h_res,
    input  O_v_total, O_v_sync, O_v_bporch, O_v_res,
    input  O_hs_pol, O_vs_pol, O_gen_rst_n
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and press detector for one button.
//   clk_i   - pixel clock
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw active-high button, asynchronous
//   press_o - registered one-cycle pulse on the 0->1 edge of the debounced level
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd540000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  // Debounce: count only while the synchronised level differs from the accepted
  // level; any return to the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q >= DEB_CYCLES - 20'd1) begin
        deb_d = sync_q[1];
        cnt_d = 20'd0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end else begin
      cnt_d = 20'd0;
    end
    press_d = deb_d & ~deb_q;
  end

  // Synchroniser, debounce and press registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      deb_q   <= 1'b0;
      cnt_q   <= 20'd0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/testpattern_ctrl.sv
// testpattern_ctrl: run-time controller for the HDMI test-pattern generator.
//   I_pxl_clk  - pixel clock (sole clock)
//   I_rst_n    - asynchronous active-low reset
//   I_btn_mode - raw pattern button; I_btn_res - raw preset button
//   I_auto_en  - quasi-static, 1 = auto-advance pattern every FRAMES_PER_PAT frames
//   O_busy     - high while the generator is held in reset (HOLD)
//   gen        - generator bundle: VS in, timing/polarity/mode/colour/reset out
// Mode and colour changes commit only at frame start so no frame tears.
module testpattern_ctrl
  import testpattern_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES     = 20'd540000,
  parameter logic [7:0]  RST_HOLD       = 8'd64,
  parameter logic [7:0]  FRAMES_PER_PAT = 8'd120,
  parameter logic [7:0]  COLOR_STEP     = 8'd4,
  parameter logic [1:0]  DEFAULT_PRESET = 2'd1
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst_n,
  input  logic          I_btn_mode,
  input  logic          I_btn_res,
  input  logic          I_auto_en,
  output logic          O_busy,
  testpattern_if.master gen
);
  logic       mode_press_s, res_press_s;
  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] preset_q, preset_d, preset_nxt_s;
  preset_t    tim_q, tim_d;
  logic       gen_rst_n_q, gen_rst_n_d;
  logic       busy_q, busy_d;
  logic [1:0] vs_sync_q;
  logic       vs_prev_q, vs_act_s, sof_s;
  logic       frame_clr_s, auto_hit_s;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       pend_q, pend_d;
  logic [2:0] mode_q, mode_d;
  logic [7:0] single_q, single_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_i(I_pxl_clk), .rst_ni(I_rst_n), .btn_i(I_btn_mode), .press_o(mode_press_s)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_res (
    .clk_i(I_pxl_clk), .rst_ni(I_rst_n), .btn_i(I_btn_res), .press_o(res_press_s)
  );

  // Normalise VS so 1 always means "inside the sync pulse", whatever the polarity.
  assign vs_act_s     = gen.I_vs ^ ~tim_q.vs_pol;
  // Frame starts are meaningless while the generator is held in reset.
  assign sof_s        = vs_sync_q[1] & ~vs_prev_q & gen_rst_n_q;
  assign preset_nxt_s = preset_q + 2'd1;

  // HOLD/RUN sequencing and preset selection.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    preset_d    = preset_q;
    tim_d       = tim_q;
    gen_rst_n_d = gen_rst_n_q;
    frame_clr_s = 1'b0;
    case (state_q)
      ST_HOLD: begin
        gen_rst_n_d = 1'b0;
        if (hold_cnt_q == RST_HOLD - 8'd1) begin
          state_d     = ST_RUN;
          hold_cnt_d  = 8'd0;
          gen_rst_n_d = 1'b1;
          frame_clr_s = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        gen_rst_n_d = 1'b1;
      end
      default: begin
        state_d     = ST_HOLD;
        hold_cnt_d  = 8'd0;
        gen_rst_n_d = 1'b0;
      end
    endcase
    // A preset press wins in either state and (re)starts the reset hold.
    if (res_press_s) begin
      preset_d    = preset_nxt_s;
      tim_d       = PRESET[preset_nxt_s];
      hold_cnt_d  = 8'd0;
      state_d     = ST_HOLD;
      gen_rst_n_d = 1'b0;
      frame_clr_s = 1'b0;
    end else begin
      preset_d = preset_d;
    end
    busy_d = (state_d == ST_HOLD);
  end

  // Pattern sequencing, auto-advance frame counting and gray-ramp level.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    mode_d      = mode_q;
    single_d    = single_q;
    auto_hit_s  = 1'b0;
    if (frame_clr_s || !I_auto_en) begin
      frame_cnt_d = 8'd0;
    end else if (sof_s) begin
      if (frame_cnt_q == FRAMES_PER_PAT - 8'd1) begin
        auto_hit_s  = 1'b1;
        frame_cnt_d = 8'd0;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    // Press, auto trigger and an older pending request all collapse into one step.
    if (sof_s && (pend_q || mode_press_s || auto_hit_s)) begin
      mode_d = next_mode(mode_q);
      pend_d = 1'b0;
      if (mode_d == MODE_SINGLE) begin
        single_d = 8'd0;
      end else begin
        single_d = single_q;
      end
    end else begin
      if (mode_press_s) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
      if (sof_s && (mode_q == MODE_SINGLE)) begin
        single_d = single_q + COLOR_STEP;
      end else begin
        single_d = single_q;
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= 8'd0;
      preset_q    <= DEFAULT_PRESET;
      tim_q       <= PRESET[DEFAULT_PRESET];
      gen_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      vs_sync_q   <= 2'b00;
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      pend_q      <= 1'b0;
      mode_q      <= MODE_BAR;
      single_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      preset_q    <= preset_d;
      tim_q       <= tim_d;
      gen_rst_n_q <= gen_rst_n_d;
      busy_q      <= busy_d;
      vs_sync_q   <= {vs_sync_q[0], vs_act_s};
      vs_prev_q   <= vs_sync_q[1];
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
      mode_q      <= mode_d;
      single_q    <= single_d;
    end
  end

  assign O_busy          = busy_q;
  assign gen.O_mode      = mode_q;
  assign gen.O_single_r  = single_q;
  assign gen.O_single_g  = single_q;
  assign gen.O_single_b  = single_q;
  assign gen.O_h_total   = tim_q.h_total;
  assign gen.O_h_sync    = tim_q.h_sync;
  assign gen.O_h_bporch  = tim_q.h_bporch;
  assign gen.O_h_res     = tim_q.h_res;
  assign gen.O_v_total   = tim_q.v_total;
  assign gen.O_v_sync    = tim_q.v_sync;
  assign gen.O_v_bporch  = tim_q.v_bporch;
  assign gen.O_v_res     = tim_q.v_res;
  assign gen.O_hs_pol    = tim_q.hs_pol;
  assign gen.O_vs_pol    = tim_q.vs_pol;
  assign gen.O_gen_rst_n = gen_rst_n_q;
endmodule
